// File: rtl/grf_write_sched.sv
// Single-write-port scheduler for the GRF: the W stage always wins the port,
// long-latency results wait in a small FIFO and drain in idle W slots.
module grf_write_sched #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          ll_valid,
  input  logic [4:0]    ll_addr,
  input  logic [31:0]   ll_data,
  output logic          ll_ready,
  output logic          grf_we,
  output logic [4:0]    grf_addr,
  output logic [31:0]   grf_data,
  input  logic [4:0]    q_a1,
  input  logic [4:0]    q_a2,
  output logic          busy1,
  output logic          busy2,
  output logic          stall_req,
  output logic [AW:0]   count
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WMAX   = WW'(MAX_WAIT);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [WW-1:0] W_ONE   = WW'(1);

  logic [4:0]       entry_addr_q [DEPTH];
  logic [31:0]      entry_data_q [DEPTH];
  logic [DEPTH-1:0] entry_vld_q;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WW-1:0]    wait_q, wait_d;

  logic wb_act, pop, push, fifo_nonempty;

  assign wb_act        = wb_we && (wb_addr != 5'd0);
  assign fifo_nonempty = (count_q != '0);
  assign ll_ready      = reset && (count_q < FULL);
  assign push          = ll_valid && ll_ready && (ll_addr != 5'd0);
  assign pop           = reset && !wb_act && fifo_nonempty;
  assign count         = count_q;
  assign stall_req     = (wait_q >= WMAX);

  // Outputs are gated by reset so a W-stage write cannot leak through while held.
  always_comb begin
    grf_we   = 1'b0;
    grf_addr = 5'd0;
    grf_data = 32'd0;
    if (reset) begin
      if (wb_act) begin
        grf_we   = 1'b1;
        grf_addr = wb_addr;
        grf_data = wb_data;
      end else if (fifo_nonempty) begin
        grf_we   = 1'b1;
        grf_addr = entry_addr_q[rd_ptr_q];
        grf_data = entry_data_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld_q[i] && (entry_addr_q[i] == q_a1) && (q_a1 != 5'd0)) busy1 = 1'b1;
      if (entry_vld_q[i] && (entry_addr_q[i] == q_a2) && (q_a2 != 5'd0)) busy2 = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The wait counter only measures cycles where a queued entry lost the port.
  always_comb begin
    wait_d = wait_q;
    if (pop || !fifo_nonempty) begin
      wait_d = '0;
    end else if (wb_act && (wait_q != WMAX)) begin
      wait_d = wait_q + W_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      entry_vld_q <= '0;
    end else begin
      count_q <= count_d;
      wait_q  <= wait_d;
      if (pop) begin
        rd_ptr_q              <= rd_ptr_q + PTR_ONE;
        entry_vld_q[rd_ptr_q] <= 1'b0;
      end
      if (push) begin
        wr_ptr_q              <= wr_ptr_q + PTR_ONE;
        entry_vld_q[wr_ptr_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr_q[wr_ptr_q] <= ll_addr;
      entry_data_q[wr_ptr_q] <= ll_data;
    end
  end

endmodule
